// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, 11-bit frame deframer with timeout,
// and a small receive FIFO with an edge-triggered, active-low pop request.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  typedef enum logic {StIdle, StShift} state_e;

  // Synchronisers and falling-edge detect
  logic [2:0] ps2c_sync_q;
  logic [1:0] ps2d_sync_q;
  logic       fall;
  logic       bit_in;

  assign fall   = ps2c_sync_q[2] & ~ps2c_sync_q[1];
  assign bit_in = ps2d_sync_q[1];

  // Deframer state
  state_e            state_q, state_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [9:0]        shreg_q, shreg_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              frame_err_q, frame_err_d;
  logic [9:0]        frame;
  logic              frame_ok;
  logic              push;

  // {stop, parity, d7..d0} as seen on the fall that samples the stop bit
  assign frame    = {bit_in, shreg_q[9:1]};
  assign frame_ok = frame[9] & (^frame[8:0]);

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    tmo_d       = tmo_q;
    if (fall) begin
      tmo_d = '0;
    end else if (tmo_q != TmoW'(TIMEOUT)) begin
      tmo_d = tmo_q + TmoW'(1);
    end

    case (state_q)
      StIdle: begin
        if (fall && !bit_in) begin
          state_d  = StShift;
          bitcnt_d = 4'd1;
          shreg_d  = '0;
        end
      end
      StShift: begin
        if (fall) begin
          shreg_d  = {bit_in, shreg_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd10) begin
            state_d  = StIdle;
            bitcnt_d = '0;
            if (frame_ok) begin
              push = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end else if (tmo_q == TmoW'(TIMEOUT)) begin
          state_d     = StIdle;
          bitcnt_d    = '0;
          frame_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      ps2c_sync_q <= 3'b111;
      ps2d_sync_q <= 2'b11;
      state_q     <= StIdle;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      ps2c_sync_q <= {ps2c_sync_q[1:0], ps2_clk};
      ps2d_sync_q <= {ps2d_sync_q[0], ps2_data};
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  // Receive FIFO
  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  overflow_q;
  logic                  nd_q;
  logic                  pop;
  logic                  full;
  logic                  wr_en;

  assign ready = (count_q != '0);
  assign data  = mem_q[rd_ptr_q];
  assign full  = (count_q == (DEPTH_LOG2 + 1)'(Depth));
  assign pop   = nd_q & ~nextdata_n & ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      nd_q       <= 1'b1;
    end else begin
      nd_q <= nextdata_n;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= frame[7:0];
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && !wr_en) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: bytes queued on send, compared on each pop.
module tb_ps2_rx_fifo;

  localparam int Depth   = 8;
  localparam int Tmo     = 1000;
  localparam int Half    = 50;
  localparam int Gap     = 20;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  bit         exp_ovf = 1'b0;
  int         cyc = 0;
  int         ferr_cnt = 0;
  int         ferr_wide = 0;
  logic       ferr_prev = 1'b0;
  logic       ready_prev = 1'b0;
  int         rise_cyc = 0;
  int         last_stop = 0;

  ps2_rx_fifo #(
    .DEPTH_LOG2(3),
    .TIMEOUT   (Tmo)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (frame_err && ferr_prev) ferr_wide <= ferr_wide + 1;
    ferr_prev <= frame_err;
    if (ready && !ready_prev) rise_cyc <= cyc;
    ready_prev <= ready;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // rst_at >= 0 aborts the frame with a one-cycle reset during that bit's high phase
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit pop_align, input int rst_at);
    logic [10:0] f;
    logic        par;
    par = ~(^b) ^ bad_par;
    f   = {~bad_stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (Half) @(negedge clk);
      if (i == rst_at) begin
        clrn = 1'b0;
        @(negedge clk);
        clrn     = 1'b1;
        ps2_data = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (Gap) @(negedge clk);
        return;
      end
      if (i == 10 && pop_align) begin
        check_eq("align_ready", ready, 1);
        check_eq("align_data", data, exp_q.pop_front());
      end
      ps2_clk = 1'b0;
      if (i == 10) last_stop = cyc;
      if (i == 10 && pop_align) begin
        // Fall is seen two edges after the pin drops; the pop lands on the push edge
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        nextdata_n = 1'b0;
        repeat (Half - 1) @(negedge clk);
      end else begin
        repeat (Half) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    nextdata_n = 1'b1;
    ps2_data   = 1'b1;
    repeat (Gap) @(negedge clk);
    if (!bad_par && !bad_stop) begin
      if (pop_align || exp_q.size() < Depth) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic pop_one();
    check_eq("pop_ready", ready, 1);
    check_eq("pop_data", data, exp_q.pop_front());
    @(negedge clk);
    nextdata_n = 1'b0;
    repeat (20) @(negedge clk);
    nextdata_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int          e0;
    int          t0;
    int          t_err;
    logic [10:0] f;

    repeat (5) @(negedge clk);
    check_eq("rst_data", data, 8'h00);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_ferr", frame_err, 0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    // Good frame, push latency, single pop on a long low pulse
    send_frame(8'h45, 0, 0, 0, -1);
    check_eq("ready_lat", rise_cyc - last_stop, 3);
    pop_one();
    check_eq("empty_after_45", ready, 0);

    // Make/break sequence
    send_frame(8'h16, 0, 0, 0, -1);
    send_frame(8'hF0, 0, 0, 0, -1);
    send_frame(8'h16, 0, 0, 0, -1);
    while (exp_q.size() > 0) pop_one();
    check_eq("empty_after_mb", ready, 0);

    // Parity and stop errors
    e0 = ferr_cnt;
    send_frame(8'h1E, 1, 0, 0, -1);
    check_eq("par_err", ferr_cnt - e0, 1);
    check_eq("par_ready", ready, 0);
    send_frame(8'h1E, 0, 1, 0, -1);
    check_eq("stop_err", ferr_cnt - e0, 2);
    check_eq("stop_ready", ready, 0);

    // Overflow and pointer wrap
    for (int v = 1; v <= 9; v++) send_frame(8'(v), 0, 0, 0, -1);
    check_eq("ovf_set", overflow, exp_ovf);
    while (exp_q.size() > 0) pop_one();
    check_eq("empty_after_ovf", ready, 0);
    send_frame(8'h0A, 0, 0, 0, -1);
    pop_one();
    check_eq("ovf_sticky", overflow, 1);

    // Reset mid-frame with bytes queued
    send_frame(8'h31, 0, 0, 0, -1);
    send_frame(8'h32, 0, 0, 0, -1);
    send_frame(8'h33, 0, 0, 0, -1);
    send_frame(8'h44, 0, 0, 0, 4);
    check_eq("mrst_ready", ready, 0);
    check_eq("mrst_data", data, 8'h00);
    check_eq("mrst_ovf", overflow, 0);
    send_frame(8'h26, 0, 0, 0, -1);
    pop_one();
    check_eq("empty_after_26", ready, 0);

    // Timeout on a 5-bit partial frame
    e0 = ferr_cnt;
    f  = {1'b1, ~(^8'h5A), 8'h5A, 1'b0};
    t0 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (Half) @(negedge clk);
      ps2_clk = 1'b0;
      t0 = cyc;
      repeat (Half) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    t_err = -1;
    for (int k = 0; k < Tmo + 50; k++) begin
      @(negedge clk);
      if (frame_err) begin
        t_err = cyc - t0;
        break;
      end
    end
    check_eq("tmo_window", (t_err >= Tmo && t_err <= Tmo + 8), 1);
    repeat (3) @(negedge clk);
    check_eq("tmo_err_cnt", ferr_cnt - e0, 1);
    check_eq("tmo_ready", ready, 0);
    send_frame(8'h25, 0, 0, 0, -1);
    pop_one();
    check_eq("empty_after_25", ready, 0);

    // Full FIFO with push and pop on the same edge
    for (int v = 0; v < 8; v++) send_frame(8'h80 + 8'(v), 0, 0, 0, -1);
    check_eq("full_no_ovf", overflow, 0);
    send_frame(8'hC9, 0, 0, 1, -1);
    check_eq("align_no_ovf", overflow, 0);
    while (exp_q.size() > 0) pop_one();
    check_eq("empty_final", ready, 0);
    check_eq("ovf_final", overflow, 0);
    check_eq("ferr_width", ferr_wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
